// File: rtl/emboss_pkg.sv
// emboss_pkg: shared states, register map and reset constants for the emboss control block.
package emboss_pkg;
  typedef enum logic [1:0] {WAIT_SYNC, RUN, COMMIT} state_t;
  localparam logic [1:0] ADDR_THR  = 2'd0;
  localparam logic [1:0] ADDR_CTL  = 2'd1;
  localparam logic [1:0] ADDR_STEP = 2'd2;
  localparam logic [1:0] ADDR_CLR  = 2'd3;
  localparam logic [7:0] THR_RST   = 8'd128;
endpackage

// File: rtl/emboss_geom_chk.sv
// emboss_geom_chk: pixel/line counters that pulse o_err_set when a line or frame has the wrong size.
module emboss_geom_chk #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic i_blank,
  input  logic i_commit,
  input  logic i_first,
  output logic o_err_set
);
  localparam logic [CNT_W-1:0] H_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_C = CNT_W'(V_ACTIVE);
  logic             r_blank;
  logic [CNT_W-1:0] r_pix, r_line;
  logic             w_eol;
  assign w_eol = i_blank & ~r_blank;
  // The partial frame before the first commit is never judged.
  assign o_err_set = ~i_first & ((w_eol & (r_pix != H_C)) | (i_commit & (r_line != V_C)));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank <= 1'b0;
      r_pix   <= '0;
      r_line  <= '0;
    end else begin
      r_blank <= i_blank;
      r_pix   <= w_eol ? '0 : (~i_blank & ~&r_pix) ? r_pix + 1'b1 : r_pix;
      r_line  <= i_commit ? {{(CNT_W-1){1'b0}}, w_eol} :
                 (w_eol & ~&r_line) ? r_line + 1'b1 : r_line;
    end
  end
endmodule

// File: rtl/emboss_ctrl.sv
// emboss_ctrl: shadows host writes and commits threshold/bypass to the emboss datapath once per frame.
module emboss_ctrl
  import emboss_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        i_HSYNC,
  input  logic        i_VSYNC,
  input  logic        i_BLANK,
  output logic [7:0]  o_shreshold,
  output logic        o_bypass,
  output logic [15:0] o_frame_cnt,
  output logic        o_geom_err
);
  state_t      r_state, w_next;
  logic        r_vs, r_ready, r_first, r_bypass, r_sweep, r_dir, r_err;
  logic [7:0]  r_sh_thr, r_sh_step, r_thr, w_sw_thr;
  logic [1:0]  r_sh_ctl;
  logic [15:0] r_fcnt;
  logic [8:0]  w_up;
  logic        w_rise, w_acc, w_commit, w_clr, w_set, w_sw_dir, w_unused;
  assign w_unused  = i_HSYNC;
  assign w_rise    = i_VSYNC & ~r_vs;
  assign w_acc     = cfg_valid & r_ready;
  assign w_commit  = r_state == COMMIT;
  assign w_clr     = w_acc & (cfg_addr == ADDR_CLR);
  assign w_up      = {1'b0, r_thr} + {1'b0, r_sh_step};
  assign w_sw_thr  = r_dir ? (w_up[8] ? 8'hFF : w_up[7:0]) :
                     (r_thr < r_sh_step) ? 8'h00 : r_thr - r_sh_step;
  assign w_sw_dir  = r_dir ? ~w_up[8] : (r_thr < r_sh_step);
  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_SYNC;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = w_commit ? RUN : (w_rise ? COMMIT : r_state);
  end
  emboss_geom_chk #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .CNT_W(CNT_W)) u_geom (
    .clk(clk), .rst(rst), .i_blank(i_BLANK), .i_commit(w_commit), .i_first(r_first), .o_err_set(w_set)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs      <= 1'b0;
      r_ready   <= 1'b0;
      r_first   <= 1'b1;
      r_sh_thr  <= THR_RST;
      r_sh_ctl  <= 2'b00;
      r_sh_step <= 8'd0;
      r_thr     <= THR_RST;
      r_bypass  <= 1'b0;
      r_sweep   <= 1'b0;
      r_dir     <= 1'b1;
      r_fcnt    <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      r_vs    <= i_VSYNC;
      r_ready <= w_next != COMMIT;
      r_first <= r_first & ~w_commit;
      r_err   <= w_set | (r_err & ~w_clr);
      r_fcnt  <= w_commit ? r_fcnt + 16'd1 : (w_clr ? 16'd0 : r_fcnt);
      if (w_acc && cfg_addr == ADDR_THR)  r_sh_thr  <= cfg_wdata;
      if (w_acc && cfg_addr == ADDR_CTL)  r_sh_ctl  <= cfg_wdata[1:0];
      if (w_acc && cfg_addr == ADDR_STEP) r_sh_step <= cfg_wdata;
      // Sweep follows the sweep_en already in force; a fresh enable restarts upward.
      if (w_commit) begin
        r_bypass <= r_sh_ctl[0];
        r_sweep  <= r_sh_ctl[1];
        r_thr    <= r_sweep ? w_sw_thr : r_sh_thr;
        r_dir    <= (r_sh_ctl[1] & ~r_sweep) ? 1'b1 : (r_sweep ? w_sw_dir : r_dir);
      end
    end
  end
  assign cfg_ready   = r_ready;
  assign o_shreshold = r_thr;
  assign o_bypass    = r_bypass;
  assign o_frame_cnt = r_fcnt;
  assign o_geom_err  = r_err;
endmodule

// File: tb/tb_emboss_ctrl.sv
// tb_emboss_ctrl: directed frames against a queue of expected commit results.
module tb_emboss_ctrl;
  localparam int H = 8;
  localparam int V = 4;
  logic        clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_ready;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        i_HSYNC = 1'b0, i_VSYNC = 1'b0, i_BLANK = 1'b1;
  logic [7:0]  o_shreshold;
  logic        o_bypass, o_geom_err;
  logic [15:0] o_frame_cnt;
  int total = 0, bad = 0;
  typedef struct packed {logic [7:0] thr; logic byp; logic [15:0] fcnt; logic err;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  emboss_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .i_HSYNC(i_HSYNC), .i_VSYNC(i_VSYNC), .i_BLANK(i_BLANK),
    .o_shreshold(o_shreshold), .o_bypass(o_bypass), .o_frame_cnt(o_frame_cnt), .o_geom_err(o_geom_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    int k = 0;
    cfg_addr = a; cfg_wdata = d; cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && k < 8) begin @(negedge clk); k++; end
    chk("wr_ready_timeout", 32'(k < 8), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic line(input int n);
    i_BLANK = 1'b0;
    repeat (n) @(negedge clk);
    i_BLANK = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input int short_line, input int nlines);
    for (int l = 0; l < nlines; l++) line(l == short_line ? H - 1 : H);
  endtask

  task automatic do_commit(input string tag, input logic [7:0] t, input logic b,
                           input logic [15:0] f, input logic e);
    exp_t x;
    sb.push_back(exp_t'{t, b, f, e});
    i_VSYNC = 1'b1;
    repeat (2) @(negedge clk);
    i_VSYNC = 1'b0;
    @(negedge clk);
    x = sb.pop_front();
    chk({tag, ".thr"}, 32'(o_shreshold), 32'(x.thr));
    chk({tag, ".byp"}, 32'(o_bypass), 32'(x.byp));
    chk({tag, ".fcnt"}, 32'(o_frame_cnt), 32'(x.fcnt));
    chk({tag, ".err"}, 32'(o_geom_err), 32'(x.err));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.thr", 32'(o_shreshold), 128);
    chk("rst.byp", 32'(o_bypass), 0);
    chk("rst.fcnt", 32'(o_frame_cnt), 0);
    chk("rst.err", 32'(o_geom_err), 0);
    chk("rst.ready", 32'(cfg_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_ready), 1);

    wr(2'd0, 8'd200);
    i_VSYNC = 1'b1;
    @(negedge clk);
    chk("ct.thr_in_commit", 32'(o_shreshold), 128);
    chk("ct.ready_in_commit", 32'(cfg_ready), 0);
    @(negedge clk);
    chk("ct.thr_after", 32'(o_shreshold), 200);
    chk("ct.fcnt", 32'(o_frame_cnt), 1);
    chk("ct.ready_after", 32'(cfg_ready), 1);
    i_VSYNC = 1'b0;
    @(negedge clk);

    frame(-1, V); do_commit("f2", 200, 0, 2, 0);

    frame(-1, V);
    i_VSYNC = 1'b1;
    @(negedge clk);
    chk("stall.ready_low", 32'(cfg_ready), 0);
    cfg_addr = 2'd0; cfg_wdata = 8'd50; cfg_valid = 1'b1;
    @(negedge clk);
    chk("stall.ready_back", 32'(cfg_ready), 1);
    chk("stall.thr_old", 32'(o_shreshold), 200);
    chk("stall.fcnt", 32'(o_frame_cnt), 3);
    @(negedge clk);
    cfg_valid = 1'b0; i_VSYNC = 1'b0;
    chk("stall.ready_once", 32'(cfg_ready), 1);
    @(negedge clk);
    frame(-1, V); do_commit("stall", 50, 0, 4, 0);

    wr(2'd0, 8'd250); wr(2'd2, 8'd4); wr(2'd1, 8'd3);
    frame(-1, V); do_commit("sw0", 250, 1, 5, 0);
    frame(-1, V); do_commit("sw1", 254, 1, 6, 0);
    frame(-1, V); do_commit("sw2", 255, 1, 7, 0);
    frame(-1, V); do_commit("sw3", 251, 1, 8, 0);
    wr(2'd2, 8'd249);
    frame(-1, V); do_commit("sw4", 2, 1, 9, 0);
    wr(2'd2, 8'd4);
    frame(-1, V); do_commit("sw5", 0, 1, 10, 0);
    frame(-1, V); do_commit("sw6", 4, 1, 11, 0);
    wr(2'd2, 8'd0); wr(2'd1, 8'd0);
    frame(-1, V); do_commit("sw_hold", 4, 0, 12, 0);
    frame(-1, V); do_commit("sw_off", 250, 0, 13, 0);

    frame(1, V); do_commit("g_short_line", 250, 0, 14, 1);
    frame(-1, V); do_commit("g_sticky", 250, 0, 15, 1);
    wr(2'd3, 8'd0);
    chk("g_clr.err", 32'(o_geom_err), 0);
    chk("g_clr.fcnt", 32'(o_frame_cnt), 0);
    frame(-1, V - 1); do_commit("g_short_frame", 250, 0, 1, 1);
    wr(2'd3, 8'd0);
    frame(-1, V); do_commit("g_good", 250, 0, 1, 0);
    i_BLANK = 1'b0;
    repeat (H - 1) @(negedge clk);
    i_BLANK = 1'b1; cfg_addr = 2'd3; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("g_clr_vs_set.err", 32'(o_geom_err), 1);
    chk("g_clr_vs_set.fcnt", 32'(o_frame_cnt), 0);
    @(negedge clk);
    frame(-1, V - 1); do_commit("g_after_race", 250, 0, 1, 1);
    wr(2'd3, 8'd0);
    chk("g_clr2.err", 32'(o_geom_err), 0);

    force dut.r_fcnt = 16'hFFFE;
    @(negedge clk);
    release dut.r_fcnt;
    frame(-1, V); do_commit("wrap_ffff", 250, 0, 16'hFFFF, 0);
    frame(-1, V); do_commit("wrap_0", 250, 0, 16'h0000, 0);

    wr(2'd0, 8'd77); wr(2'd1, 8'd1);
    frame(-1, V); do_commit("pre_rst", 77, 1, 1, 0);
    i_BLANK = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst.thr", 32'(o_shreshold), 128);
    chk("mid_rst.byp", 32'(o_bypass), 0);
    chk("mid_rst.fcnt", 32'(o_frame_cnt), 0);
    chk("mid_rst.err", 32'(o_geom_err), 0);
    chk("mid_rst.ready", 32'(cfg_ready), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    i_BLANK = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst.partial_line_err", 32'(o_geom_err), 0);
    line(5);
    do_commit("post_rst1", 128, 0, 1, 0);
    frame(-1, V); do_commit("post_rst2", 128, 0, 2, 0);
    frame(2, V); do_commit("post_rst3", 128, 0, 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
